// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser followed by a consecutive-sample debounce counter.
// Define BUTTON_INVERT_EN for active-low buttons with pull-ups (pin is inverted before sync).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic init,
  input  logic button_raw,
  output logic button_clean,
  output logic bouncing
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  logic             btn_in;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             bouncing_q, bouncing_d;
  logic             mismatch, terminal;
`ifdef BUTTON_INVERT_EN
  assign btn_in = ~button_raw;
`else
  assign btn_in = button_raw;
`endif
  // Any sample matching the accepted level drops the count straight back to zero.
  always_comb begin
    mismatch   = sync2_q != clean_q;
    terminal   = cnt_q == LAST;
    cnt_d      = (mismatch && !terminal) ? cnt_q + 1'b1 : '0;
    clean_d    = (mismatch && terminal) ? sync2_q : clean_q;
    bouncing_d = cnt_d != '0;
  end
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      clean_q    <= 1'b0;
      bouncing_q <= 1'b0;
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      clean_q    <= clean_d;
      bouncing_q <= bouncing_d;
    end
  end
  assign button_clean = clean_q;
  assign bouncing     = bouncing_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and randomized checks of button_debounce against a
// sample-window model (accept a level once the last D delayed samples all differ).
module tb_button_debounce;
  localparam int D = 4;
`ifdef BUTTON_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  logic clk = 1'b0;
  logic init = 1'b0;
  logic button_raw = 1'b0;
  logic button_clean, bouncing;
  int   errs = 0, checks = 0;
  bit   done = 1'b0;

  button_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .init(init), .button_raw(button_raw),
    .button_clean(button_clean), .bouncing(bouncing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: history of logical pin samples, one per edge; the edge's decision sees
  // the sample from two edges earlier. Reset fills history with zeros.
  bit hq[$];
  bit m_clean = 1'b0, m_bounce = 1'b0;
  always @(posedge clk or negedge init) begin
    bit all_diff;
    if (!init || hq.size() != D + 2) begin
      hq = {};
      repeat (D + 2) hq.push_back(1'b0);
      m_clean  = 1'b0;
      m_bounce = 1'b0;
    end else begin
      hq.push_back(button_raw ^ INV);
      void'(hq.pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (hq[i] == m_clean) all_diff = 1'b0;
      if (all_diff) m_clean = ~m_clean;
      m_bounce = hq[D-1] != m_clean;
    end
  end

  always @(negedge clk) if (!done) begin
    chk("model_clean", button_clean, m_clean);
    chk("model_bouncing", bouncing, m_bounce);
  end

  task automatic set(input bit lvl);
    @(negedge clk);
    #1 button_raw = lvl ^ INV;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    button_raw = 1'b1 ^ INV;
    repeat (5) begin
      after_edge();
      chk("reset_clean", button_clean, 1'b0);
      chk("reset_bouncing", bouncing, 1'b0);
    end
    set(1'b0);
    init = 1'b1;
    repeat (8) set(1'b0);
    // clean press: bouncing from edge 3, clean on edge 6
    set(1'b1);
    for (int i = 1; i <= 8; i++) begin
      after_edge();
      chk("press_bouncing", bouncing, (i >= 3 && i <= 5));
      chk("press_clean", button_clean, i >= 6);
    end
    repeat (10) set(1'b0);
    chk("release_clean", button_clean, 1'b0);
    // glitch: exactly three high samples
    set(1'b1);
    repeat (3) @(posedge clk);
    #1 button_raw = 1'b0 ^ INV;
    for (int i = 0; i < 10; i++) begin
      after_edge();
      chk("glitch_clean", button_clean, 1'b0);
    end
    chk("glitch_bouncing", bouncing, 1'b0);
    // bounce burst then hold high
    for (int i = 0; i < 20; i++) begin
      set(i % 2 == 0);
      chk("burst_clean", button_clean, 1'b0);
    end
    set(1'b1);
    for (int i = 1; i <= 8; i++) begin
      after_edge();
      chk("burst_hold_clean", button_clean, i >= 6);
    end
    repeat (10) set(1'b0);
    // reset mid-count
    set(1'b1);
    repeat (4) @(posedge clk);
    #1 init = 1'b0;
    #1;
    chk("midrst_bouncing", bouncing, 1'b0);
    chk("midrst_clean", button_clean, 1'b0);
    @(negedge clk);
    #1 init = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      after_edge();
      chk("midrst_reaccept", button_clean, i >= 6);
    end
    // randomized runs with occasional resets
    for (int n = 0; n < 400; n++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 40) == 0) begin
        @(negedge clk);
        #1 init = 1'b0;
        @(negedge clk);
        #1 init = 1'b1;
      end
      repeat (len) set(lvl);
    end
    @(negedge clk);
    #1 done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
